// File: rtl/imem_responder_if.sv
// Fetch and program-load bus between the PC-side requester
// and the instruction-memory responder.
interface imem_responder_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic        load;
    logic        fault;
    logic        busy;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output req, addr, wr_en, wr_addr, wr_data,
        input  instr, instr_valid, load, fault, busy
    );

    modport slave (
        input  req, addr, wr_en, wr_addr, wr_data,
        output instr, instr_valid, load, fault, busy
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: wait-stated fetch with one load
// pulse per completed fetch, plus a boot-time write port.
module imem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    imem_responder_if.slave bus
);
    localparam int          AW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT = 4'(LATENCY);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic        fault_q;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        fault_r, fault_d;
    logic        busy_q, busy_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          acc_fault;
    logic          wr_ok;
    logic          rd_fault;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic          unused_ok;

    assign accept    = (state_q == IDLE) && bus.req && !bus.wr_en;
    assign acc_fault = (bus.addr[1:0] != 2'b00)
                     || (bus.addr[31:2] >= 30'(DEPTH_WORDS));
    assign wr_ok     = (state_q == IDLE) && bus.wr_en
                     && (bus.wr_addr[1:0] == 2'b00)
                     && (bus.wr_addr[31:2] < 30'(DEPTH_WORDS));
    assign wr_idx    = bus.wr_addr[AW+1:2];

    // A zero-latency fetch reads on the acceptance edge, before addr_q is loaded
    assign rd_idx   = (state_q == IDLE) ? bus.addr[AW+1:2] : addr_q[AW+1:2];
    assign rd_fault = (state_q == IDLE) ? acc_fault : fault_q;

    assign unused_ok = ^{addr_q[31:AW+2], addr_q[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            fault_q <= 1'b0;
            instr_q <= NOP;
            valid_q <= 1'b0;
            fault_r <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= bus.addr;
                fault_q <= acc_fault;
            end
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_r <= fault_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_ok)
            mem[wr_idx] <= bus.wr_data;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = LAT;
                    state_d = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_d = instr_q;
        if (state_d == RESP)
            instr_d = rd_fault ? NOP : mem[rd_idx];
        valid_d = (state_d == RESP);
        fault_d = (state_d == RESP) && rd_fault;
        busy_d  = (state_d != IDLE);
    end

    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.load        = valid_q;
    assign bus.fault       = fault_r;
    assign bus.busy        = busy_q;
endmodule
